// File: rtl/act_skew_feeder_pkg.sv
// Shared configuration for the activation skew feeder.
//   CFG_ROWS        : systolic array rows = number of skew lanes
//   CFG_A_BITWIDTH  : activation element width
//   feed_state_e    : feeder sequencing states
package act_skew_feeder_pkg;

  localparam int CFG_ROWS       = 4;
  localparam int CFG_A_BITWIDTH = 8;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_STREAM,
    FEED_DRAIN
  } feed_state_e;

endpackage

// File: rtl/act_skew_feeder_skew_delay_line.sv
// Valid+data shift register of fixed depth with synchronous clear.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   clr              : synchronous clear of every stage (en and data)
//   in_en, in_data   : value entering stage 0 every cycle
//   out_en, out_data : value leaving the last stage (DEPTH cycles later)
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_en,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            en_q;
  logic [DEPTH-1:0]            en_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;

  always_comb begin
    en_d      = en_q;
    data_d    = data_q;
    en_d[0]   = in_en;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      en_d[i]   = en_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      en_q   <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
    end
  end

  assign out_en   = en_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: accepts one activation vector per handshake and
// delays row i by i extra cycles so the array sees a diagonal wavefront.
// Counts vectors of a tile, drains the skew lanes and pulses done.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, tile_len    : begin a tile of tile_len vectors (IDLE only)
//   abort              : cancel tile, flush lanes, no done
//   in_valid, in_data  : activation vector from the buffer
//   in_ready           : vector accepted this cycle when in_valid is high
//   if_en, if_data     : skewed outputs to the array west edge
//   busy               : high while streaming or draining
//   done               : one-cycle pulse after the last vector leaves the last lane
//
// state       | meaning
// FEED_IDLE   | waiting for start
// FEED_STREAM | accepting vectors until tile_len have been taken
// FEED_DRAIN  | no more accepts, waiting for the last vector to leave lane ROWS-1
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int SMALL_SYS_ROWS = CFG_ROWS,
  parameter int A_BITWIDTH     = CFG_A_BITWIDTH,
  parameter int LEN_W          = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [LEN_W-1:0]                           tile_len,
  input  logic                                       abort,
  input  logic                                       in_valid,
  input  logic [SMALL_SYS_ROWS-1:0][A_BITWIDTH-1:0]  in_data,
  output logic                                       in_ready,
  output logic [SMALL_SYS_ROWS-1:0]                  if_en,
  output logic [SMALL_SYS_ROWS-1:0][A_BITWIDTH-1:0]  if_data,
  output logic                                       busy,
  output logic                                       done
);

  localparam int DRAIN_W = $clog2(SMALL_SYS_ROWS + 1);

  feed_state_e        state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   tile_len_q, tile_len_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic               accept;

  // abort wins over a vector offered in the same cycle
  assign in_ready = !rst && !abort && (state_q == FEED_STREAM) && (count_q < tile_len_q);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != FEED_IDLE);
  assign done     = done_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tile_len_d = tile_len_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d = FEED_IDLE;
      count_d = '0;
      drain_d = '0;
    end else begin
      case (state_q)
        FEED_IDLE: begin
          if (start) begin
            if (tile_len != '0) begin
              state_d    = FEED_STREAM;
              tile_len_d = tile_len;
              count_d    = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        FEED_STREAM: begin
          if (accept) begin
            count_d = count_q + LEN_W'(1);
            if (count_q == tile_len_q - LEN_W'(1)) begin
              state_d = FEED_DRAIN;
              // last vector needs ROWS cycles to clear lane ROWS-1
              drain_d = DRAIN_W'(SMALL_SYS_ROWS);
            end
          end
        end
        FEED_DRAIN: begin
          if (drain_q == DRAIN_W'(1)) begin
            state_d = FEED_IDLE;
            drain_d = '0;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
        default: state_d = FEED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FEED_IDLE;
      count_q    <= '0;
      tile_len_q <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tile_len_q <= tile_len_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
    end
  end

  for (genvar g = 0; g < SMALL_SYS_ROWS; g++) begin : g_lane
    skew_delay_line #(
      .DEPTH(g + 1),
      .WIDTH(A_BITWIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (abort),
      .in_en   (accept),
      .in_data (accept ? in_data[g] : '0),
      .out_en  (if_en[g]),
      .out_data(if_data[g])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder (4 rows, 8-bit activations).
// Stimulus pushes expected lane beats and done pulses, each stamped with the
// cycle they must appear in; a negedge monitor pops and compares.
module tb_act_skew_feeder;

  localparam int ROWS = 4;
  localparam int AW   = 8;

  typedef struct {
    logic [AW-1:0] d;
    int            c;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [15:0]              tile_len;
  logic                     abort;
  logic                     in_valid;
  logic [ROWS-1:0][AW-1:0]  in_data;
  logic                     in_ready;
  logic [ROWS-1:0]          if_en;
  logic [ROWS-1:0][AW-1:0]  if_data;
  logic                     busy;
  logic                     done;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t lane_q[ROWS][$];
  int   done_q[$];

  act_skew_feeder #(
    .SMALL_SYS_ROWS(ROWS),
    .A_BITWIDTH    (AW),
    .LEN_W         (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tile_len(tile_len),
    .abort   (abort),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .if_en   (if_en),
    .if_data (if_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int base);
    for (int i = 0; i < ROWS; i++) in_data[i] = AW'(base + i);
  endtask

  task automatic push_lane(input int lane, input int data, input int c);
    exp_t e;
    e.d = AW'(data);
    e.c = c;
    lane_q[lane].push_back(e);
  endtask

  // vector accepted in cycle c: element i must show on lane i in cycle c+1+i
  task automatic push_vec(input int base, input int c);
    for (int i = 0; i < ROWS; i++) push_lane(i, base + i, c + 1 + i);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < ROWS; i++) begin
        if (if_en[i] === 1'b1) begin
          n_checks++;
          if (lane_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL lane%0d_unexpected at cycle %0d: got data %0d, expected no beat", i, cyc, if_data[i]);
          end else begin
            exp_t e;
            e = lane_q[i].pop_front();
            if (if_data[i] !== e.d || cyc != e.c) begin
              n_fail++;
              $display("FAIL lane%0d_beat: got data %0d at cycle %0d, expected data %0d at cycle %0d",
                       i, if_data[i], cyc, e.d, e.c);
            end
          end
        end
      end
      if (done === 1'b1) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected at cycle %0d: got done=1, expected 0", cyc);
        end else begin
          int c;
          c = done_q.pop_front();
          if (cyc != c) begin
            n_fail++;
            $display("FAIL done_cycle: got cycle %0d, expected cycle %0d", cyc, c);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; tile_len = '0; abort = 1'b0;
    in_valid = 1'b1; set_vec(100);

    // reset held 3 cycles with in_valid high
    step(); step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_if_en", 32'(if_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    step();

    // back-to-back tile of 3
    start = 1'b1; tile_len = 16'd3;
    step();
    start = 1'b0; t0 = cyc;
    in_valid = 1'b1; set_vec(1); #1;
    chk("t2_in_ready_t0", 32'(in_ready), 1);
    chk("t2_busy", 32'(busy), 1);
    push_vec(1, t0); step();
    set_vec(5); push_vec(5, t0 + 1); step();
    set_vec(9); push_vec(9, t0 + 2); step();
    set_vec(13); #1;
    chk("t2_in_ready_t3", 32'(in_ready), 0);
    done_q.push_back(t0 + 7);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("t2_busy_after", 32'(busy), 0);

    // tile of 3 with a bubble at t1
    start = 1'b1; tile_len = 16'd3;
    step();
    start = 1'b0; t0 = cyc;
    in_valid = 1'b1; set_vec(1); push_vec(1, t0); step();
    in_valid = 1'b0; set_vec(50); step();
    in_valid = 1'b1; set_vec(5); push_vec(5, t0 + 2); step();
    set_vec(9); push_vec(9, t0 + 3); step();
    set_vec(13); #1;
    chk("t3_in_ready_t4", 32'(in_ready), 0);
    done_q.push_back(t0 + 8);
    in_valid = 1'b0;
    repeat (6) step();
    chk("t3_busy_after", 32'(busy), 0);

    // zero-length tile
    start = 1'b1; tile_len = 16'd0;
    done_q.push_back(cyc + 1);
    step();
    start = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    step();
    chk("t4_busy_later", 32'(busy), 0);
    chk("t4_if_en", 32'(if_en), 0);

    // abort at t2 of a 5-vector tile
    start = 1'b1; tile_len = 16'd5;
    step();
    start = 1'b0; t0 = cyc;
    in_valid = 1'b1; set_vec(1);
    push_lane(0, 1, t0 + 1); push_lane(1, 2, t0 + 2);
    step();
    set_vec(5); push_lane(0, 5, t0 + 2);
    step();
    set_vec(9); abort = 1'b1; #1;
    chk("t5_in_ready_abort", 32'(in_ready), 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_if_en", 32'(if_en), 0);
    step();
    chk("t5_if_en_later", 32'(if_en), 0);
    repeat (4) step();
    // fresh single-vector tile after abort
    start = 1'b1; tile_len = 16'd1;
    step();
    start = 1'b0; t0 = cyc;
    in_valid = 1'b1; set_vec(21); #1;
    chk("t5_restart_ready", 32'(in_ready), 1);
    push_vec(21, t0); done_q.push_back(t0 + 5);
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // start during DRAIN is ignored
    start = 1'b1; tile_len = 16'd2;
    step();
    start = 1'b0; t0 = cyc;
    in_valid = 1'b1; set_vec(30); push_vec(30, t0); step();
    set_vec(34); push_vec(34, t0 + 1); done_q.push_back(t0 + 6); step();
    start = 1'b1; tile_len = 16'd7; set_vec(40); #1;
    chk("t6_in_ready_drain", 32'(in_ready), 0);
    step();
    start = 1'b0;
    chk("t6_in_ready_drain2", 32'(in_ready), 0);
    chk("t6_busy_drain", 32'(busy), 1);
    repeat (4) step();
    chk("t6_busy_after", 32'(busy), 0);
    chk("t6_in_ready_after", 32'(in_ready), 0);
    in_valid = 1'b0;
    repeat (3) step();
    chk("t6_busy_final", 32'(busy), 0);

    for (int i = 0; i < ROWS; i++) chk($sformatf("lane%0d_pending", i), 32'(lane_q[i].size()), 0);
    chk("done_pending", 32'(done_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
